// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Operands load on an accepted start; the result lands in sum/cout one cycle after the last bit.
`timescale 1ns/1ps

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             sum_bit,
    output logic             sum_bit_valid,
    output logic [1:0]       dbg_state_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic fa_s;
    logic fa_c;

    // The single full-adder cell, fed by the low bits of the operand shift registers.
    always_comb begin
        fa_s = a_q[0] ^ b_q[0] ^ carry_q;
        fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end

            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                // Shift-plus-OR form keeps the MSB insert legal when WIDTH is 1.
                acc_d   = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    sum_d   = acc_d;
                    cout_d  = fa_c;
                end
            end

            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        busy          = (state_q == S_RUN);
        done          = (state_q == S_DONE);
        sum_bit_valid = busy;
        sum_bit       = busy & fa_s;
        sum           = sum_q;
        cout          = cout_q;
        dbg_state_o   = state_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances, arithmetic reference model,
// queued expectations popped by monitors whenever the DUT presents a bit or a done.
`timescale 1ns/1ps

module tb_serial_adder;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // WIDTH=8 instance
  logic         start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, sum_bit, sum_bit_valid;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .sum_bit(sum_bit), .sum_bit_valid(sum_bit_valid), .dbg_state_o(dbg_state)
  );

  // WIDTH=1 instance
  logic       start1, a1, b1, cin1;
  logic       busy1, done1, sum1, cout1, sum_bit1, sum_bit_valid1;
  logic [1:0] dbg_state1;

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .sum_bit(sum_bit1), .sum_bit_valid(sum_bit_valid1), .dbg_state_o(dbg_state1)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int done8_cnt = 0;
  logic [W:0] exp_q[$];
  logic       exp_bit_q[$];
  logic [1:0] exp1_q[$];
  logic       exp1_bit_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain integer addition
  function automatic logic [W:0] ref_add8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int r;
    r = int'(x) + int'(y) + int'(c);
    return r[W:0];
  endfunction

  function automatic logic [1:0] ref_add1(input logic x, input logic y, input logic c);
    int r;
    r = int'(x) + int'(y) + int'(c);
    return r[1:0];
  endfunction

  // driver tasks
  task automatic push_exp8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = ref_add8(x, y, c);
    exp_q.push_back(r);
    for (int i = 0; i < W; i++) exp_bit_q.push_back(r[i]);
  endtask

  task automatic issue8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; start = 1'b1;
    push_exp8(x, y, c);
    @(posedge clk); #1;
    start = 1'b0;
    // scramble operands after acceptance; the DUT must ignore them
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done8(output int lat);
    int  n;
    bit  seen;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk("done8_within_budget", 32'(seen), 32'd1);
    lat = n;
  endtask

  task automatic issue1(input logic x, input logic y, input logic c);
    logic [1:0] r;
    r = ref_add1(x, y, c);
    a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
    exp1_q.push_back(r);
    exp1_bit_q.push_back(r[0]);
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
  endtask

  task automatic wait_done1(output int lat);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (done1) seen = 1;
    end
    chk("done1_within_budget", 32'(seen), 32'd1);
    lat = n;
  endtask

  // monitors
  task automatic monitor8();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sum_bit_valid) begin
          if (exp_bit_q.size() == 0) chk("w8_bit_unrequested", 32'(exp_bit_q.size()), 32'd1);
          else chk("w8_sum_bit", 32'(sum_bit), 32'(exp_bit_q.pop_front()));
        end
        if (done) begin
          done8_cnt++;
          if (exp_q.size() == 0) chk("w8_done_unrequested", 32'(exp_q.size()), 32'd1);
          else chk("w8_cout_sum", 32'({cout, sum}), 32'(exp_q.pop_front()));
        end
      end
    end
  endtask

  task automatic monitor1();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sum_bit_valid1) begin
          if (exp1_bit_q.size() == 0) chk("w1_bit_unrequested", 32'(exp1_bit_q.size()), 32'd1);
          else chk("w1_sum_bit", 32'(sum_bit1), 32'(exp1_bit_q.pop_front()));
        end
        if (done1) begin
          if (exp1_q.size() == 0) chk("w1_done_unrequested", 32'(exp1_q.size()), 32'd1);
          else chk("w1_cout_sum", 32'({cout1, sum1}), 32'(exp1_q.pop_front()));
        end
      end
    end
  endtask

  initial begin
    int lat;
    int d0;
    logic [W-1:0] x, y;
    logic c;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    fork
      monitor8();
      monitor1();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_sum_bit", 32'(sum_bit), 32'd0);
    chk("rst_sum_bit_valid", 32'(sum_bit_valid), 32'd0);
    chk("rst_w1_busy_done", 32'({busy1, done1, sum1, cout1}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0x5A + 0x33: serial stream and 9-cycle latency
    issue8(8'h5A, 8'h33, 1'b0);
    chk("busy_in_run", 32'(busy), 32'd1);
    wait_done8(lat);
    chk("latency_5a_33", 32'(lat), 32'd9);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);

    // carry-out cases; previous result must hold through RUN
    issue8(8'hFF, 8'h01, 1'b0);
    chk("sum_holds_in_run", 32'({cout, sum}), 32'(ref_add8(8'h5A, 8'h33, 1'b0)));
    wait_done8(lat);
    @(posedge clk); #1;
    issue8(8'hFF, 8'hFF, 1'b1);
    wait_done8(lat);
    @(posedge clk); #1;

    // start during RUN is ignored
    d0 = done8_cnt;
    issue8(8'h10, 8'h20, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done8(lat);
    repeat (12) begin @(posedge clk); #1; end
    chk("single_done_ignored_start", 32'(done8_cnt - d0), 32'd1);

    // reset in the 4th RUN cycle aborts without done or sum update
    issue8(8'h12, 8'h34, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    exp_q.delete();
    exp_bit_q.delete();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    d0 = done8_cnt;
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_done", 32'(done8_cnt - d0), 32'd0);
    issue8(8'h01, 8'h01, 1'b0);
    wait_done8(lat);
    @(posedge clk); #1;

    // start held high through DONE: back-to-back with no idle cycle
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    push_exp8(8'h0F, 8'h01, 1'b0);
    @(posedge clk); #1;
    a = 8'h80; b = 8'h80; cin = 1'b0;
    push_exp8(8'h80, 8'h80, 1'b0);
    wait_done8(lat);
    chk("b2b_first_latency", 32'(lat), 32'd9);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_no_idle_gap", 32'(busy), 32'd1);
    wait_done8(lat);
    chk("b2b_second_latency", 32'(lat), 32'd9);

    // randomized operations, random gaps (gap 0 exercises DONE->RUN)
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom_range(0, 1));
      if (n == 0) begin x = 8'hFF; y = 8'h00; c = 1'b1; end
      issue8(x, y, c);
      wait_done8(lat);
      chk("rand_latency", 32'(lat), 32'd9);
    end
    @(posedge clk); #1;

    // WIDTH=1 build
    issue1(1'b1, 1'b1, 1'b1);
    chk("w1_busy", 32'(busy1), 32'd1);
    wait_done1(lat);
    chk("w1_latency", 32'(lat), 32'd2);
    chk("w1_sum_111", 32'({cout1, sum1}), 32'd3);
    @(posedge clk); #1;
    for (int n = 0; n < 12; n++) begin
      issue1(1'($urandom), 1'($urandom), 1'($urandom));
      wait_done1(lat);
      chk("w1_rand_latency", 32'(lat), 32'd2);
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("w8_results_drained", 32'(exp_q.size()), 32'd0);
    chk("w8_bits_drained", 32'(exp_bit_q.size()), 32'd0);
    chk("w1_results_drained", 32'(exp1_q.size()), 32'd0);
    chk("w1_bits_drained", 32'(exp1_bit_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
